// File: rtl/program_rom_server.sv
// Instruction-fetch responder for the mpp core: serves bytes from an internal program image
// after a fixed number of wait states, with a ready/valid loader and an EOI debug counter.
module program_rom_server #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] program_addr,
    input  logic        rom_cs,
    input  logic        rom_rd,
    input  logic        eoi,
    output logic [7:0]  instruction,
    output logic        instr_valid,
    output logic        addr_fault,
    input  logic        load_en,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        load_overflow,
    output logic [15:0] eoi_count
);
    localparam int unsigned      Depth    = 1 << ADDR_W;
    localparam logic [3:0]       WaitInit = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]  LastPtr  = (ADDR_W + 1)'(Depth - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDrive, StLoad} state_e;

    state_e          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic [ADDR_W:0] ptr_q, ptr_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     eoi_q, eoi_d;
    logic            mem_we;
    logic            req;
    logic            in_range;
    logic [7:0]      mem_rdata;

    logic [7:0] mem [Depth];

    assign req       = rom_cs & rom_rd;
    assign in_range  = 32'(addr_q) < Depth;
    assign mem_rdata = mem[addr_q[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            eoi_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            eoi_q   <= eoi_d;
        end
    end

    // Program image survives reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[ADDR_W-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
        eoi_d   = eoi_q + 16'(eoi);
        unique case (state_q)
            StIdle: begin
                if (load_en) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end else if (req) begin
                    state_d = StWait;
                    addr_d  = program_addr;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StDrive;
                    valid_d = 1'b1;
                    if (in_range) begin
                        instr_d = mem_rdata;
                    end else begin
                        instr_d = FILL_BYTE;
                        fault_d = 1'b1;
                    end
                end
            end
            StDrive: begin
                if (!req) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end else if (program_addr != addr_q) begin
                    state_d = StWait;
                    valid_d = 1'b0;
                    addr_d  = program_addr;
                    cnt_d   = WaitInit;
                end
            end
            StLoad: begin
                if (load_valid && load_ready) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == LastPtr) begin
                        ovf_d = 1'b1;
                    end
                end
                if (!load_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_ready    = (state_q == StLoad) && !ovf_q && (32'(ptr_q) < Depth);
        instruction   = instr_q;
        instr_valid   = valid_q;
        addr_fault    = fault_q;
        load_overflow = ovf_q;
        eoi_count     = eoi_q;
    end
endmodule

// File: tb/tb_program_rom_server.sv
// Randomized self-checking bench for program_rom_server against a byte-array reference model.
module tb_program_rom_server;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned WAIT_CYCLES = 1;
    localparam int unsigned Depth       = 1 << ADDR_W;
    localparam logic [7:0]  Fill        = 8'h00;
    localparam int          ExpLat      = WAIT_CYCLES + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] program_addr = '0;
    logic        rom_cs = 1'b0;
    logic        rom_rd = 1'b0;
    logic        eoi = 1'b0;
    logic [7:0]  instruction;
    logic        instr_valid;
    logic        addr_fault;
    logic        load_en = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        load_overflow;
    logic [15:0] eoi_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] model_mem [Depth];
    int exp_eoi = 0;

    program_rom_server #(
        .ADDR_W(ADDR_W),
        .WAIT_CYCLES(WAIT_CYCLES),
        .FILL_BYTE(Fill)
    ) dut (
        .clk(clk),
        .reset(reset),
        .program_addr(program_addr),
        .rom_cs(rom_cs),
        .rom_rd(rom_rd),
        .eoi(eoi),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .addr_fault(addr_fault),
        .load_en(load_en),
        .load_data(load_data),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_overflow(load_overflow),
        .eoi_count(eoi_count)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        return (32'(a) < Depth) ? model_mem[a[ADDR_W-1:0]] : Fill;
    endfunction

    // Drives a fetch and returns the number of edges until instr_valid, or -1 on timeout.
    task automatic do_fetch(input logic [15:0] a, output int lat);
        program_addr = a;
        rom_cs = 1'b1;
        rom_rd = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (instr_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic load_bytes(input logic [7:0] bytes [$]);
        load_en = 1'b1;
        cycle();
        foreach (bytes[i]) begin
            load_valid = 1'b1;
            load_data = bytes[i];
            cycle();
            model_mem[i] = bytes[i];
        end
        load_valid = 1'b0;
        load_en = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cycle();
        checks++;
        if (instruction !== 8'h00 || instr_valid !== 1'b0 || addr_fault !== 1'b0 ||
            load_ready !== 1'b0 || load_overflow !== 1'b0 || eoi_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got instr=%h v=%b f=%b rdy=%b ovf=%b eoi=%0d want all zero",
                     instruction, instr_valid, addr_fault, load_ready, load_overflow, eoi_count);
        end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_load_fetch();
        logic [7:0] b [$];
        int lat;
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        load_bytes(b);
        do_fetch(16'h0002, lat);
        checks++;
        if (lat !== ExpLat || instruction !== model_read(16'h0002)) begin
            failures++;
            $display("FAIL load_fetch: got lat=%0d instr=%h want lat=%0d instr=%h",
                     lat, instruction, ExpLat, model_read(16'h0002));
        end
        checks++;
        if (addr_fault !== 1'b0) begin
            failures++;
            $display("FAIL load_fetch_fault: got %b want 0", addr_fault);
        end
    endtask

    task automatic test_addr_step();
        int lat;
        for (int a = 0; a < 3; a++) begin
            do_fetch(16'(a), lat);
            checks++;
            if (lat !== ExpLat || instruction !== model_read(16'(a))) begin
                failures++;
                $display("FAIL addr_step[%0d]: got lat=%0d instr=%h want lat=%0d instr=%h",
                         a, lat, instruction, ExpLat, model_read(16'(a)));
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        do_fetch(16'h0400, lat);
        checks++;
        if (lat !== ExpLat || instruction !== Fill || addr_fault !== 1'b1) begin
            failures++;
            $display("FAIL oob_fetch: got lat=%0d instr=%h f=%b want lat=%0d instr=%h f=1",
                     lat, instruction, addr_fault, ExpLat, Fill);
        end
        rom_cs = 1'b0;
        rom_rd = 1'b0;
        cycle();
        checks++;
        if (addr_fault !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL oob_sticky: got f=%b v=%b want f=1 v=0", addr_fault, instr_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d [Depth];
        int lat;
        for (int i = 0; i < int'(Depth); i++) d[i] = 8'($urandom);
        load_en = 1'b1;
        cycle();
        load_valid = 1'b1;
        for (int i = 0; i < int'(Depth) + 3; i++) begin
            load_data = (i < int'(Depth)) ? d[i] : ~d[0];
            cycle();
            if (i == int'(Depth) - 2) begin
                checks++;
                if (load_overflow !== 1'b0 || load_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_before_last: got ovf=%b rdy=%b want ovf=0 rdy=1",
                             load_overflow, load_ready);
                end
            end
            if (i == int'(Depth) - 1 || i == int'(Depth) + 2) begin
                checks++;
                if (load_overflow !== 1'b1 || load_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_after_last[%0d]: got ovf=%b rdy=%b want ovf=1 rdy=0",
                             i, load_overflow, load_ready);
                end
            end
        end
        load_valid = 1'b0;
        load_en = 1'b0;
        cycle();
        for (int i = 0; i < int'(Depth); i++) model_mem[i] = d[i];
        do_fetch(16'h0000, lat);
        checks++;
        if (lat !== ExpLat || instruction !== d[0]) begin
            failures++;
            $display("FAIL ovf_mem0: got lat=%0d instr=%h want lat=%0d instr=%h",
                     lat, instruction, ExpLat, d[0]);
        end
        do_fetch(16'(Depth - 1), lat);
        checks++;
        if (lat !== ExpLat || instruction !== d[Depth-1]) begin
            failures++;
            $display("FAIL ovf_memlast: got lat=%0d instr=%h want lat=%0d instr=%h",
                     lat, instruction, ExpLat, d[Depth-1]);
        end
        rom_cs = 1'b0;
        rom_rd = 1'b0;
        cycle();
    endtask

    task automatic test_load_priority();
        program_addr = 16'h0005;
        rom_cs = 1'b1;
        rom_rd = 1'b1;
        load_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (load_ready !== 1'b1 || instr_valid !== 1'b0 || load_overflow !== 1'b0) begin
                failures++;
                $display("FAIL load_priority[%0d]: got rdy=%b v=%b ovf=%b want rdy=1 v=0 ovf=0",
                         i, load_ready, instr_valid, load_overflow);
            end
        end
        rom_cs = 1'b0;
        rom_rd = 1'b0;
        load_en = 1'b0;
        cycle();
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_exit_ready: got %b want 0", load_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        logic [15:0] a;
        eoi = 1'b1;
        repeat (5) cycle();
        eoi = 1'b0;
        exp_eoi += 5;
        checks++;
        if (eoi_count !== 16'(exp_eoi)) begin
            failures++;
            $display("FAIL eoi_pulses: got %0d want %0d", eoi_count, exp_eoi);
        end
        program_addr = 16'h0010;
        rom_cs = 1'b1;
        rom_rd = 1'b1;
        cycle();
        #2 reset = 1'b0;
        #1;
        exp_eoi = 0;
        checks++;
        if (instr_valid !== 1'b0 || eoi_count !== 16'd0 || addr_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait: got v=%b eoi=%0d f=%b want v=0 eoi=0 f=0",
                     instr_valid, eoi_count, addr_fault);
        end
        rom_cs = 1'b0;
        rom_rd = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        a = 16'($urandom_range(0, Depth - 1));
        do_fetch(a, lat);
        checks++;
        if (lat !== ExpLat || instruction !== model_read(a)) begin
            failures++;
            $display("FAIL post_reset_fetch: got lat=%0d instr=%h want lat=%0d instr=%h",
                     lat, instruction, ExpLat, model_read(a));
        end
    endtask

    task automatic test_random_fetch();
        int lat;
        logic [15:0] a;
        logic [15:0] prev = addr_fault ? 16'hFFFF : program_addr;
        logic exp_fault = addr_fault;
        rom_rd = 1'b0;
        repeat (4) cycle();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL cs_without_rd: got v=%b want 0", instr_valid);
        end
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, Depth - 1));
            if (a == prev || $urandom_range(0, 2) == 0) begin
                rom_cs = 1'b0;
                rom_rd = 1'b0;
                cycle();
            end
            do_fetch(a, lat);
            prev = a;
            if (32'(a) >= Depth) exp_fault = 1'b1;
            checks++;
            if (lat !== ExpLat || instruction !== model_read(a) || addr_fault !== exp_fault) begin
                failures++;
                $display("FAIL rand_fetch[%0d] a=%h: got lat=%0d instr=%h f=%b want %0d %h %b",
                         n, a, lat, instruction, addr_fault, ExpLat, model_read(a), exp_fault);
            end
        end
        rom_cs = 1'b0;
        rom_rd = 1'b0;
        cycle();
    endtask

    task automatic test_eoi_random();
        for (int n = 0; n < 60; n++) begin
            eoi = 1'($urandom);
            if (eoi) exp_eoi++;
            cycle();
            if (n % 15 == 14) begin
                checks++;
                if (eoi_count !== 16'(exp_eoi)) begin
                    failures++;
                    $display("FAIL eoi_random[%0d]: got %0d want %0d", n, eoi_count, exp_eoi);
                end
            end
        end
        eoi = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_addr_step();
        test_out_of_range();
        test_overflow();
        test_load_priority();
        test_reset_mid_wait();
        test_random_fetch();
        test_eoi_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_rom_server.md
Name: program_rom_server

Overview:
- Program-memory responder for the mpp core's instruction-fetch interface.
- Answers the core's 16-bit program_addr and ROMcs/ROMrd strobes with instruction bytes, after a fixed number of wait states.
- Holds the program image in internal byte memory, filled through a ready/valid loader port.
- Counts EOI pulses for debug.

Parameters:
- ADDR_W, 10, internal memory address width; depth = 2^ADDR_W bytes.
- WAIT_CYCLES, 1, wait states inserted between request sample and data valid (0..15).
- FILL_BYTE, 8'h00, byte returned for addresses at or beyond the memory depth.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- program_addr  in  16  fetch address from the core.
- rom_cs  in  1  chip select from the core (ROMcs).
- rom_rd  in  1  read strobe from the core (ROMrd).
- eoi  in  1  end-of-instruction pulse from the core.
- instruction  out  8  instruction byte to the core.
- instr_valid  out  1  instruction holds data for the current program_addr.
- addr_fault  out  1  sticky flag: a fetch addressed beyond the memory depth.
- load_en  in  1  loader mode request.
- load_data  in  8  loader byte.
- load_valid  in  1  loader byte valid.
- load_ready  out  1  loader can accept a byte this cycle.
- load_overflow  out  1  sticky flag: the loader filled the whole memory.
- eoi_count  out  16  count of EOI pulses, wraps modulo 2^16.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - instruction=8'h00; instr_valid, addr_fault, load_ready, load_overflow all 0; eoi_count=0.
  - Load pointer = 0 and wait counter = 0.
  - Memory contents are not cleared.
- Releasing reset mid-fetch or mid-load restarts in IDLE. The core must re-request.
- Request: req = rom_cs & rom_rd, sampled at each rising edge.
- States: IDLE, WAIT, DRIVE, LOAD.
- IDLE:
  - load_en=1 → LOAD. Loader takes priority over a simultaneous req.
  - Else req=1 → latch program_addr into addr_q; go to WAIT with counter = WAIT_CYCLES.
- WAIT:
  - Counter is nonzero → decrement it.
  - Counter is zero → go to DRIVE and register the output byte:
    - addr_q < 2^ADDR_W: instruction = mem[addr_q].
    - Otherwise: instruction = FILL_BYTE and set addr_fault.
  - In the same edge, set instr_valid=1.
  - Latency: request sampled at edge N gives instr_valid high after edge N+1+WAIT_CYCLES.
  - req dropping in WAIT → IDLE; instr_valid stays 0.
- DRIVE:
  - instr_valid stays 1 while req=1 and program_addr == addr_q.
  - program_addr changes with req=1 → instr_valid=0, latch the new address, go to WAIT (full latency again).
  - req=0 → instr_valid=0, go to IDLE; instruction keeps its last value.
- LOAD:
  - Entry clears the load pointer to 0 and load_overflow to 0.
  - load_ready=1 while the pointer < 2^ADDR_W and load_overflow=0.
  - Each edge with load_valid & load_ready: write mem[pointer]=load_data, then increment the pointer.
  - Writing the last location (pointer = 2^ADDR_W-1) sets load_overflow=1 and load_ready=0. Later bytes are dropped and the pointer does not wrap.
  - Fetch requests during LOAD are ignored and instr_valid stays 0.
  - load_en=0 → IDLE, load_ready=0. Memory is readable from the next request.
- eoi_count: increments by 1 on each edge where eoi=1, in every state except while reset is asserted.
- addr_fault: cleared only by reset.

Test Plan:
1. Load 4 bytes (A0,A1,A2,A3) → load_en=0 → fetch addr 0x0002, WAIT_CYCLES=1.
   - Required: instr_valid rises 2 edges after the request edge with instruction=A2; addr_fault=0.
2. Hold req and step program_addr 0→1→2, waiting for valid each time.
   - Required: instr_valid drops for 2 cycles after each change, then shows A0, A1, A2 in order.
3. Fetch 0x0400 (ADDR_W=10).
   - Required: instruction=8'h00, instr_valid=1, addr_fault=1 and still 1 after req drops.
4. Load all 1024 bytes plus 3 extra with load_valid held high.
   - Required: load_overflow=1 after byte 1024; load_ready=0; mem[0] is unchanged by the extra bytes.
5. Assert load_en and req in the same IDLE cycle.
   - Required: state is LOAD, load_ready=1, instr_valid stays 0 throughout.
6. Assert reset low mid-WAIT after 5 eoi pulses.
   - Required: instr_valid=0 and eoi_count=0 immediately; after release, a new fetch returns correct data after normal latency.
